// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: the program/run control, the instruction memory
// port, the redirect request and the decode handshake.
//   master : fetch_ctrl side (drives imem_pc and the if_* / status outputs)
//   slave  : surrounding pipeline and memory side
// Signals:
//   run            level enable for fetching
//   imem_pc        instruction memory byte address
//   imem_instr     instruction memory read data (combinational from imem_pc)
//   redirect_valid single-cycle flow change request
//   redirect_pc    redirect target
//   if_valid       head of skid buffer holds an instruction
//   if_ready       decode accepts head this cycle
//   if_instr       head instruction
//   if_pc          byte address of head instruction
//   halted         program end reached and buffer drained
//   fault          misaligned redirect seen; sticky until reset
interface fetch_ctrl_if #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   run;
    logic [PC_WIDTH-1:0]    imem_pc;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   if_valid;
    logic                   if_ready;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]    if_pc;
    logic                   halted;
    logic                   fault;

    modport master (
        input  run, imem_instr, redirect_valid, redirect_pc, if_ready,
        output imem_pc, if_valid, if_instr, if_pc, halted, fault
    );

    modport slave (
        output run, imem_instr, redirect_valid, redirect_pc, if_ready,
        input  imem_pc, if_valid, if_instr, if_pc, halted, fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer. Owns the PC, addresses the instruction
// memory, captures returned instructions into a 2-entry skid buffer and
// presents them to decode over valid/ready. Handles redirects, halting at
// the end of the program and misaligned-redirect faults.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fetch_ctrl_if.master (memory port, redirect, decode handshake, status)
module fetch_ctrl #(
    parameter int unsigned         PC_WIDTH    = 16,
    parameter int unsigned         INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000,
    parameter logic [PC_WIDTH-1:0] PROG_LIMIT  = 16'h0032,
    parameter int unsigned         PC_STEP     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INSTR_WIDTH-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   fault_q, fault_d;

    logic                   pop;
    logic                   push;
    logic [1:0]             slot;

    // Next-state, PC and skid-buffer update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        ins0_d   = ins0_q;
        ins1_d   = ins1_q;
        push     = 1'b0;
        pop      = (cnt_q != 2'd0) && bus.if_ready;
        // Tail slot once a same-cycle pop has shifted the buffer
        slot     = cnt_q - {1'b0, pop};

        if (bus.redirect_valid && (state_q != S_FAULT)) begin
            // Flush wins over any pop/push this cycle; head payload is left as-is
            cnt_d = 2'd0;
            if (bus.redirect_pc[0]) begin
                state_d = S_FAULT;
            end else begin
                pc_d    = bus.redirect_pc;
                state_d = S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.run) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (pc_q >= PROG_LIMIT) state_d = S_HALT;
                    else                    push = bus.run && ((cnt_q != 2'd2) || pop);
                end
                S_HALT, S_FAULT: begin
                end
                default: state_d = S_IDLE;
            endcase

            // Pop shifts the second entry forward; a lone head is held on pop
            if (pop && (cnt_q == 2'd2)) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
            end
            if (push) begin
                if (slot == 2'd0) begin
                    pc0_d  = pc_q;
                    ins0_d = bus.imem_instr;
                end else begin
                    pc1_d  = pc_q;
                    ins1_d = bus.imem_instr;
                end
                pc_d = pc_q + PC_WIDTH'(PC_STEP);
            end
            cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};
        end

        valid_d  = (cnt_d != 2'd0);
        halted_d = (state_d == S_HALT) && (cnt_d == 2'd0);
        fault_d  = (state_d == S_FAULT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= 2'd0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            ins0_q   <= '0;
            ins1_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            ins0_q   <= ins0_d;
            ins1_q   <= ins1_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.imem_pc  = pc_q;
    assign bus.if_valid = valid_q;
    assign bus.if_instr = ins0_q;
    assign bus.if_pc    = pc0_q;
    assign bus.halted   = halted_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run checked
// against a queue-based model of the fetch sequencer.
module tb_fetch_ctrl;

    localparam logic [15:0] LIMIT = 16'h0032;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    assign bus.imem_instr = {mem[8'(bus.imem_pc + 16'd1)], mem[bus.imem_pc[7:0]]};

    int   checks = 0;
    int   fails  = 0;

    // Model: mode 0 idle, 1 fetching, 2 halted at end, 3 faulted
    int          m_mode;
    logic [15:0] m_pc;
    ent_t        mq[$];

    function automatic logic [15:0] word(input logic [15:0] a);
        return {mem[8'(a + 16'd1)], mem[a[7:0]]};
    endfunction

    // Advance model with the inputs about to be sampled, then clock the DUT
    task automatic step();
        bit   pop;
        bit   push;
        ent_t e;
        pop  = 1'b0;
        push = 1'b0;
        if (!rst_n) begin
            m_mode = 0;
            m_pc   = 16'h0000;
            mq.delete();
        end else if (bus.redirect_valid && m_mode != 3) begin
            mq.delete();
            if (bus.redirect_pc[0]) m_mode = 3;
            else begin
                m_pc   = bus.redirect_pc;
                m_mode = 1;
            end
        end else begin
            pop = (mq.size() > 0) && bus.if_ready;
            if (m_mode == 0) begin
                if (bus.run) m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_pc >= LIMIT) m_mode = 2;
                else push = bus.run && ((mq.size() - int'(pop)) < 2);
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc    = m_pc;
                e.instr = word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.run            = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.if_valid !== 1'b0)     begin fails++; $display("FAIL reset_if_valid got %0b exp 0", bus.if_valid); end
        checks++; if (bus.imem_pc !== 16'h0000)  begin fails++; $display("FAIL reset_imem_pc got %h exp 0000", bus.imem_pc); end
        checks++; if (bus.if_instr !== 16'h0000) begin fails++; $display("FAIL reset_if_instr got %h exp 0000", bus.if_instr); end
        checks++; if (bus.if_pc !== 16'h0000)    begin fails++; $display("FAIL reset_if_pc got %h exp 0000", bus.if_pc); end
        checks++; if (bus.halted !== 1'b0)       begin fails++; $display("FAIL reset_halted got %0b exp 0", bus.halted); end
        checks++; if (bus.fault !== 1'b0)        begin fails++; $display("FAIL reset_fault got %0b exp 0", bus.fault); end
    endtask

    task automatic test_stream();
        logic [15:0] a;
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b1;
        step();
        checks++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL stream_first_edge if_valid got %0b exp 0", bus.if_valid); end
        for (int i = 0; i < 25; i++) begin
            step();
            a = 16'(2 * i);
            checks++; if (bus.if_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, bus.if_valid); end
            checks++; if (bus.if_pc !== a)       begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.if_pc, a); end
            checks++; if (bus.if_instr !== word(a)) begin fails++; $display("FAIL stream_instr[%0d] got %h exp %h", i, bus.if_instr, word(a)); end
        end
        step();
        checks++; if (bus.if_valid !== 1'b0)    begin fails++; $display("FAIL stream_end_valid got %0b exp 0", bus.if_valid); end
        checks++; if (bus.halted !== 1'b1)      begin fails++; $display("FAIL stream_halted got %0b exp 1", bus.halted); end
        checks++; if (bus.imem_pc !== LIMIT)    begin fails++; $display("FAIL stream_imem_pc got %h exp %h", bus.imem_pc, LIMIT); end
        step();
        checks++; if (bus.imem_pc !== LIMIT)    begin fails++; $display("FAIL stream_imem_pc_hold got %h exp %h", bus.imem_pc, LIMIT); end
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++; if (bus.if_pc !== 16'h0008) begin fails++; $display("FAIL bp_start_pc got %h exp 0008", bus.if_pc); end
        bus.if_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.if_valid !== 1'b1)   begin fails++; $display("FAIL bp_stall_valid got %0b exp 1", bus.if_valid); end
        checks++; if (bus.if_pc !== 16'h0008)  begin fails++; $display("FAIL bp_stall_pc got %h exp 0008", bus.if_pc); end
        checks++; if (bus.imem_pc !== 16'h000C) begin fails++; $display("FAIL bp_stall_imem_pc got %h exp 000c", bus.imem_pc); end
        bus.if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            a = 16'h000A + 16'(2 * k);
            checks++; if (bus.if_pc !== a) begin fails++; $display("FAIL bp_release_pc[%0d] got %h exp %h", k, bus.if_pc, a); end
            checks++; if (bus.if_instr !== word(a)) begin fails++; $display("FAIL bp_release_instr[%0d] got %h exp %h", k, bus.if_instr, word(a)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.if_ready = 1'b0;
        step();
        step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0010; bus.if_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0)    begin fails++; $display("FAIL redir_flush_valid got %0b exp 0", bus.if_valid); end
        checks++; if (bus.imem_pc !== 16'h0010) begin fails++; $display("FAIL redir_imem_pc got %h exp 0010", bus.imem_pc); end
        step();
        checks++; if (bus.if_valid !== 1'b1)    begin fails++; $display("FAIL redir_target_valid got %0b exp 1", bus.if_valid); end
        checks++; if (bus.if_pc !== 16'h0010)   begin fails++; $display("FAIL redir_target_pc got %h exp 0010", bus.if_pc); end
        checks++; if (bus.if_instr !== word(16'h0010)) begin fails++; $display("FAIL redir_target_instr got %h exp %h", bus.if_instr, word(16'h0010)); end
        step();
        checks++; if (bus.if_pc !== 16'h0012)   begin fails++; $display("FAIL redir_next_pc got %h exp 0012", bus.if_pc); end
    endtask

    task automatic test_halt_redirect();
        int n;
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b1;
        n = 0;
        while (bus.halted !== 1'b1 && n < 80) begin step(); n++; end
        checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_reach got %0b exp 1 within 80 cycles", bus.halted); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0004;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.halted !== 1'b0)      begin fails++; $display("FAIL halt_redir_halted got %0b exp 0", bus.halted); end
        checks++; if (bus.imem_pc !== 16'h0004) begin fails++; $display("FAIL halt_redir_imem_pc got %h exp 0004", bus.imem_pc); end
        step();
        checks++; if (bus.if_valid !== 1'b1)    begin fails++; $display("FAIL halt_redir_valid got %0b exp 1", bus.if_valid); end
        checks++; if (bus.if_pc !== 16'h0004)   begin fails++; $display("FAIL halt_redir_pc got %h exp 0004", bus.if_pc); end
    endtask

    task automatic test_fault();
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h000F;
        step();
        checks++; if (bus.fault !== 1'b1)       begin fails++; $display("FAIL fault_set got %0b exp 1", bus.fault); end
        checks++; if (bus.if_valid !== 1'b0)    begin fails++; $display("FAIL fault_valid got %0b exp 0", bus.if_valid); end
        checks++; if (bus.imem_pc !== 16'h0006) begin fails++; $display("FAIL fault_imem_pc got %h exp 0006", bus.imem_pc); end
        bus.redirect_pc = 16'h0020;
        for (int i = 0; i < 3; i++) step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.fault !== 1'b1)       begin fails++; $display("FAIL fault_sticky got %0b exp 1", bus.fault); end
        checks++; if (bus.imem_pc !== 16'h0006) begin fails++; $display("FAIL fault_ignore_redir got %h exp 0006", bus.imem_pc); end
        checks++; if (bus.if_valid !== 1'b0)    begin fails++; $display("FAIL fault_hold_valid got %0b exp 0", bus.if_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.fault !== 1'b0)       begin fails++; $display("FAIL fault_clear got %0b exp 0", bus.fault); end
        checks++; if (bus.imem_pc !== 16'h0000) begin fails++; $display("FAIL fault_reset_imem_pc got %h exp 0000", bus.imem_pc); end
        checks++; if (bus.if_pc !== 16'h0000)   begin fails++; $display("FAIL fault_reset_if_pc got %h exp 0000", bus.if_pc); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (bus.imem_pc !== 16'h0004) begin fails++; $display("FAIL mid_full_imem_pc got %h exp 0004", bus.imem_pc); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.if_valid !== 1'b0)    begin fails++; $display("FAIL mid_reset_valid got %0b exp 0", bus.if_valid); end
        checks++; if (bus.imem_pc !== 16'h0000) begin fails++; $display("FAIL mid_reset_imem_pc got %h exp 0000", bus.imem_pc); end
        checks++; if (bus.halted !== 1'b0)      begin fails++; $display("FAIL mid_reset_halted got %0b exp 0", bus.halted); end
        checks++; if (bus.fault !== 1'b0)       begin fails++; $display("FAIL mid_reset_fault got %0b exp 0", bus.fault); end
    endtask

    task automatic test_random();
        logic        ev;
        logic [15:0] rpc;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n              = ($urandom % 150) != 0;
            bus.run            = ($urandom % 8) != 0;
            bus.if_ready       = ($urandom % 3) != 0;
            bus.redirect_valid = ($urandom % 24) == 0;
            rpc                = 16'($urandom % 64) & 16'hFFFE;
            if (($urandom % 4) == 0) rpc = rpc | 16'h0001;
            bus.redirect_pc    = rpc;
            step();
            ev = (mq.size() > 0);
            checks++; if (bus.if_valid !== ev) begin fails++; $display("FAIL rand_valid c=%0d got %0b exp %0b", c, bus.if_valid, ev); end
            checks++; if (bus.imem_pc !== m_pc) begin fails++; $display("FAIL rand_imem_pc c=%0d got %h exp %h", c, bus.imem_pc, m_pc); end
            checks++; if (bus.halted !== (m_mode == 2 && mq.size() == 0)) begin fails++; $display("FAIL rand_halted c=%0d got %0b exp %0b", c, bus.halted, (m_mode == 2 && mq.size() == 0)); end
            checks++; if (bus.fault !== (m_mode == 3)) begin fails++; $display("FAIL rand_fault c=%0d got %0b exp %0b", c, bus.fault, (m_mode == 3)); end
            if (ev) begin
                checks++; if (bus.if_pc !== mq[0].pc) begin fails++; $display("FAIL rand_if_pc c=%0d got %h exp %h", c, bus.if_pc, mq[0].pc); end
                checks++; if (bus.if_instr !== mq[0].instr) begin fails++; $display("FAIL rand_if_instr c=%0d got %h exp %h", c, bus.if_instr, mq[0].instr); end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        m_mode = 0;
        m_pc   = 16'h0000;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_fault();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

endmodule
